// File: rtl/encoder_4x2_stream_if.sv
// Streaming bundle for the 4-to-2 encoder: the sample side (in_*, d0..d3) and the
// encoded-result side (out_*, a0/a1, out_multi).
interface encoder_4x2_stream_if;
  logic in_valid;
  logic in_ready;
  logic d0;
  logic d1;
  logic d2;
  logic d3;
  logic out_valid;
  logic out_ready;
  logic a0;
  logic a1;
  logic out_multi;

  modport master (
    output in_valid, d0, d1, d2, d3, out_ready,
    input  in_ready, out_valid, a0, a1, out_multi
  );

  modport slave (
    input  in_valid, d0, d1, d2, d3, out_ready,
    output in_ready, out_valid, a0, a1, out_multi
  );
endinterface

// File: rtl/encoder_4x2_stream.sv
// Registered 4-to-2 priority encoder (d3 highest) feeding a small circular FIFO;
// all-zero samples are dropped and counted in a saturating error counter.
module encoder_4x2_stream #(
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  encoder_4x2_stream_if.slave  bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [3:0]           lines;
  logic [1:0]           index;
  logic [2:0]           pair_hit;
  logic                 multi;
  logic                 zero_in;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [2:0]           head;

  logic [2:0]           mem_reg [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;

  assign lines   = {bus.d3, bus.d2, bus.d1, bus.d0};
  assign zero_in = ~|lines;

  // A line that shares the input with any higher active line means two or more are set.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pair
      assign pair_hit[gi] = lines[gi] & (|lines[3:gi+1]);
    end
  endgenerate
  assign multi = |pair_hit;

  always_comb begin
    index = 2'd0;
    if (lines[3])      index = 2'd3;
    else if (lines[2]) index = 2'd2;
    else if (lines[1]) index = 2'd1;
    else               index = 2'd0;
  end

  // Handshake flags come only from registered occupancy, never from in_valid/out_ready.
  assign full   = (count_reg == CNT_W'(DEPTH));
  assign empty  = (count_reg == '0);
  assign accept = bus.in_valid && !full;
  assign push   = accept && !zero_in;
  assign pop    = !empty && bus.out_ready;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    err_cnt_next = err_cnt_reg;
    if (push)
      wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    if (pop)
      rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;
    if (accept && zero_in && (err_cnt_reg != '1))
      err_cnt_next = err_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      err_cnt_reg <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_n && push)
      mem_reg[wr_ptr_reg] <= {multi, index};
  end

  assign head          = empty ? 3'b000 : mem_reg[rd_ptr_reg];
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.a0        = head[0];
  assign bus.a1        = head[1];
  assign bus.out_multi = head[2];
  assign err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_encoder_4x2_stream.sv
// Directed bench for encoder_4x2_stream: vector table plus hand-written backpressure,
// wrap, saturation and reset sequences on DEPTH=2 instances.
module tb_encoder_4x2_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] err_a;
  logic [1:0] err_b;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  encoder_4x2_stream_if ifa ();
  encoder_4x2_stream_if ifb ();

  encoder_4x2_stream #(.DEPTH(2), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .err_cnt(err_a)
  );

  encoder_4x2_stream #(.DEPTH(2), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .err_cnt(err_b)
  );

  typedef struct {
    logic [3:0] d;
    logic [1:0] exp_a;
    logic       exp_multi;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic drive_a(input logic v, input logic [3:0] d);
    ifa.in_valid = v;
    {ifa.d3, ifa.d2, ifa.d1, ifa.d0} = d;
  endtask

  task automatic drive_b(input logic v, input logic [3:0] d);
    ifb.in_valid = v;
    {ifb.d3, ifb.d2, ifb.d1, ifb.d0} = d;
  endtask

  function automatic int head_a();
    return int'({ifa.a1, ifa.a0});
  endfunction

  initial begin
    vecs[0] = '{d: 4'b0001, exp_a: 2'd0, exp_multi: 1'b0};
    vecs[1] = '{d: 4'b0010, exp_a: 2'd1, exp_multi: 1'b0};
    vecs[2] = '{d: 4'b0100, exp_a: 2'd2, exp_multi: 1'b0};
    vecs[3] = '{d: 4'b1000, exp_a: 2'd3, exp_multi: 1'b0};
    vecs[4] = '{d: 4'b0110, exp_a: 2'd2, exp_multi: 1'b1};
    vecs[5] = '{d: 4'b1011, exp_a: 2'd3, exp_multi: 1'b1};

    drive_a(1'b0, 4'b0000);
    drive_b(1'b0, 4'b0000);
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b1;

    // Reset, with a sample offered that must be ignored
    drive_a(1'b1, 4'b0100);
    tick();
    tick();
    drive_a(1'b0, 4'b0000);
    rst_n = 1'b1;
    check("reset_out_valid", int'(ifa.out_valid), 0);
    check("reset_a", head_a(), 0);
    check("reset_multi", int'(ifa.out_multi), 0);
    check("reset_err_cnt", int'(err_a), 0);
    check("reset_in_ready", int'(ifa.in_ready), 1);
    tick();
    check("reset_sample_ignored", int'(ifa.out_valid), 0);

    // Table: one-hot sweep and multi-hot priority, streaming with out_ready=1
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, vecs[i].d);
      tick();
      $display("vec %0d d=%b a=%0d multi=%0d", i, vecs[i].d, head_a(), ifa.out_multi);
      check("vec_out_valid", int'(ifa.out_valid), 1);
      check("vec_a", head_a(), int'(vecs[i].exp_a));
      check("vec_multi", int'(ifa.out_multi), int'(vecs[i].exp_multi));
      check("vec_in_ready", int'(ifa.in_ready), 1);
    end
    drive_a(1'b0, 4'b0000);
    tick();
    check("drain_empty", int'(ifa.out_valid), 0);

    // Zero samples: counted, never queued; ERR_CNT_W=2 instance saturates at 3
    for (int k = 1; k <= 5; k++) begin
      drive_a(1'b1, 4'b0000);
      drive_b(1'b1, 4'b0000);
      tick();
      $display("zero sample %0d err_a=%0d err_b=%0d", k, err_a, err_b);
      check("zero_err_a", int'(err_a), k);
      check("zero_err_b_sat", int'(err_b), (k > 3) ? 3 : k);
      check("zero_no_valid_a", int'(ifa.out_valid), 0);
      check("zero_no_valid_b", int'(ifb.out_valid), 0);
    end
    drive_a(1'b0, 4'b0000);
    drive_b(1'b0, 4'b0000);
    tick();
    check("zero_err_hold", int'(err_a), 5);

    // Backpressure to full, then drain in order
    ifa.out_ready = 1'b0;
    drive_a(1'b1, 4'b0001);
    tick();
    check("bp_first_valid", int'(ifa.out_valid), 1);
    check("bp_first_a", head_a(), 0);
    check("bp_in_ready_1", int'(ifa.in_ready), 1);
    drive_a(1'b1, 4'b0010);
    tick();
    check("bp_full_in_ready", int'(ifa.in_ready), 0);
    check("bp_head_stable", head_a(), 0);
    drive_a(1'b1, 4'b0100);
    tick();
    check("bp_stalled_in_ready", int'(ifa.in_ready), 0);
    check("bp_head_stable2", head_a(), 0);
    ifa.out_ready = 1'b1;
    tick();
    $display("drain pop 1 a=%0d in_ready=%0d", head_a(), ifa.in_ready);
    check("bp_pop1_a", head_a(), 1);
    check("bp_pop1_in_ready", int'(ifa.in_ready), 1);
    tick();
    drive_a(1'b0, 4'b0000);
    $display("drain pop 2 a=%0d", head_a());
    check("bp_pop2_valid", int'(ifa.out_valid), 1);
    check("bp_pop2_a", head_a(), 2);
    tick();
    check("bp_drained", int'(ifa.out_valid), 0);

    // Occupancy 1 with push+pop every cycle across pointer wraps
    ifa.out_ready = 1'b0;
    drive_a(1'b1, 4'b0001);
    tick();
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, 4'b0001 << ((i + 1) % 4));
      tick();
      $display("wrap %0d a=%0d", i, head_a());
      check("wrap_a", head_a(), (i + 1) % 4);
      check("wrap_valid", int'(ifa.out_valid), 1);
      check("wrap_in_ready", int'(ifa.in_ready), 1);
    end
    drive_a(1'b0, 4'b0000);
    tick();
    check("wrap_drained", int'(ifa.out_valid), 0);

    // Reset mid-stream: FIFO full and err_cnt=2
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ifa.out_ready = 1'b0;
    drive_a(1'b1, 4'b0000);
    tick();
    tick();
    drive_a(1'b1, 4'b0110);
    tick();
    drive_a(1'b1, 4'b0011);
    tick();
    check("pre_rst_err", int'(err_a), 2);
    check("pre_rst_full", int'(ifa.in_ready), 0);
    check("pre_rst_head_multi", int'(ifa.out_multi), 1);
    rst_n = 1'b0;
    drive_a(1'b1, 4'b1000);
    tick();
    rst_n = 1'b1;
    drive_a(1'b0, 4'b0000);
    $display("after reset valid=%0d err=%0d in_ready=%0d", ifa.out_valid, err_a, ifa.in_ready);
    check("rst_mid_valid", int'(ifa.out_valid), 0);
    check("rst_mid_a", head_a(), 0);
    check("rst_mid_multi", int'(ifa.out_multi), 0);
    check("rst_mid_err", int'(err_a), 0);
    check("rst_mid_in_ready", int'(ifa.in_ready), 1);
    drive_a(1'b1, 4'b1000);
    tick();
    drive_a(1'b0, 4'b0000);
    check("post_rst_valid", int'(ifa.out_valid), 1);
    check("post_rst_a", head_a(), 3);
    tick();
    check("post_rst_one_entry", int'(ifa.in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_4x2_stream.md
# encoder_4x2_stream

Registered 4-to-2 priority encoder with a valid/ready streaming interface and a small output FIFO. It is the inverse of the team's 2x4 decoder. It takes the decoder-style lines d0..d3 and returns the 2-bit index {a1,a0}, flagging inputs that are not one-hot. It sits in front of any consumer that applies backpressure, so encoded events are buffered rather than lost.

## Interface

Parameters:
- DEPTH, 2: output FIFO depth in entries; power of two, 2..8.
- ERR_CNT_W, 8: width of the saturating zero-input error counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  d0..d3 carry a sample this cycle.
- in_ready  output  1  block can accept a sample; equals !full.
- d0, d1, d2, d3  input  1 each  request lines; d3 highest priority.
- out_valid  output  1  FIFO head holds an encoded entry.
- out_ready  input  1  consumer accepts the head this cycle.
- a0, a1  output  1 each  encoded index of the head, {a1,a0}.
- out_multi  output  1  the head entry came from more than one active line.
- err_cnt  output  ERR_CNT_W  count of accepted all-zero samples; saturates.

## Operation

- A sample is accepted when in_valid && in_ready && rst_n.
- Encoding of an accepted sample:
  - {a1,a0} is the index of the highest set line (d3→11, d2→10, d1→01, d0→00).
  - out_multi=1 when the popcount of d3..d0 is ≥2.
- Zero sample (all lines 0):
  - The sample is accepted but not written to the FIFO.
  - err_cnt increments by 1 and holds at 2^ERR_CNT_W−1.
- FIFO:
  - Circular buffer of DEPTH entries, each 3 bits {multi,a1,a0}.
  - Write pointer, read pointer, and an occupancy count of width clog2(DEPTH)+1.
  - Pointers wrap from DEPTH−1 to 0.
- A pop occurs when out_valid && out_ready.
- Push and pop in the same cycle: occupancy is unchanged and both pointers advance.
- When the FIFO is full, in_ready=0 even if out_ready=1 in that cycle; there is no full-bypass.
- When the FIFO is empty:
  - out_valid=0, and out_ready is ignored.
  - a0, a1 and out_multi drive 0.
- A zero sample never consumes a slot. It is still gated by in_ready, so it is not counted while the FIFO is full.
- Reset (rst_n=0 at a clock edge):
  - Occupancy and both pointers go to 0, and err_cnt goes to 0.
  - Any entries in flight are discarded.
  - Inputs sampled in that cycle are ignored.
- Reset values of all outputs:
  - out_valid=0, a0=0, a1=0, out_multi=0, err_cnt=0.
  - in_ready=1 from the first cycle after reset, since the FIFO is empty.

## Timing

- Latency: a sample accepted at edge N is at the head with out_valid=1 after edge N, assuming the FIFO was empty. There is no combinational path from d* to a*.
- in_ready and out_valid are decoded from registered occupancy only. They never depend combinationally on in_valid or out_ready.
- Head outputs are stable while out_valid=1 && out_ready=0.
- Throughput: 1 sample per cycle sustained while out_ready=1.
- When the FIFO is full and out_ready rises, the pop at edge N makes in_ready=1 after edge N. One idle input cycle is inherent.
- err_cnt updates at the same edge as the accept of the zero sample.
- Reset mid-operation with the FIFO full: out_valid=0 and in_ready=1 after the reset edge.

## Test plan

- One-hot sweep, out_ready=1:
  - Stimulus: d=0001, 0010, 0100, 1000 on consecutive cycles.
  - Response: {a1,a0}=00, 01, 10, 11 with out_multi=0, each one cycle after its accept.
- Priority and multi-hot:
  - Stimulus: d=0110, then 1011.
  - Response: {a1,a0}=10 with out_multi=1, then 11 with out_multi=1.
- Zero input:
  - Stimulus: three samples of d=0000.
  - Response: err_cnt=3 and out_valid stays 0.
  - Saturation with ERR_CNT_W=2 forced: 5 zero samples give err_cnt=3.
- Backpressure and full, DEPTH=2:
  - Stimulus: out_ready=0 while pushing d=0001, 0010, 0100.
  - Response: the first two are accepted and in_ready drops to 0, so the third is stalled.
  - Then raise out_ready: pops return 00, 01, then 10, in order.
- Simultaneous push/pop and wrap:
  - Stimulus: with occupancy 1, push and pop every cycle for 10 cycles.
  - Response: occupancy stays 1, pointers wrap, and the outputs match the inputs in order.
- Reset mid-stream:
  - Stimulus: FIFO full and err_cnt=2, then rst_n=0 for one edge.
  - Response: out_valid=0, a0=a1=out_multi=0, err_cnt=0 and in_ready=1 on the next cycle; the first push afterwards emerges one cycle later.
